// File: rtl/mux8_arb_defs_pkg.sv
// rtl/mux8_arb_defs_pkg.sv - shared constants and state encoding for the mux8 4:1 arbiter
package mux8_arb_defs;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/mux8_4x1.sv
// rtl/mux8_4x1.sv - 8-bit 4:1 mux library cell
module mux8_4x1 (
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic [7:0] in3,
   input  logic [7:0] in4,
   input  logic [1:0] sel,
   output logic [7:0] out
);

   // select one of four bytes by the 2-bit select code
   always_comb begin
      case (sel)
         2'd0:    out = in1;
         2'd1:    out = in2;
         2'd2:    out = in3;
         default: out = in4;
      endcase
   end

endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational pick of the first active request scanning from ptr
module rr_pick4
   import mux8_arb_defs::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [1:0]         idx,
   output logic               any
);

   logic [1:0] cand;

   // scan from the far end back toward ptr so the nearest active request wins last
   always_comb begin
      idx  = 2'd0;
      cand = 2'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ptr + 2'(k);
         if (req[cand]) begin
            idx = cand;
         end
      end
      any    = |req;
      winner = any ? (4'b0001 << idx) : 4'b0000;
   end

endmodule

// File: rtl/mux8_4x1_arbiter.sv
// rtl/mux8_4x1_arbiter.sv - 4-requester arbiter driving the mux8_4x1 select; MUX8_ARB_RR_EN enables round-robin
module mux8_4x1_arbiter
   import mux8_arb_defs::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [DATA_W-1:0]    in1,
   input  logic [DATA_W-1:0]    in2,
   input  logic [DATA_W-1:0]    in3,
   input  logic [DATA_W-1:0]    in4,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [DATA_W-1:0]    out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic [1:0]          pick_ptr;
   logic [NUM_REQ-1:0]  win_onehot;
   logic [1:0]          win_idx;
   logic                win_any;
   logic                accept;
   logic [DATA_W-1:0]   mux_out;

`ifdef MUX8_ARB_RR_EN
   logic [1:0]          ptr_q, ptr_d;
   assign pick_ptr = ptr_q;
`else
   assign pick_ptr = 2'd0;
`endif

   rr_pick4 u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .winner (win_onehot),
      .idx    (win_idx),
      .any    (win_any)
   );

   mux8_4x1 u_mux (
      .in1 (in1),
      .in2 (in2),
      .in3 (in3),
      .in4 (in4),
      .sel (win_idx),
      .out (mux_out)
   );

   // a new byte is taken when the output slot is empty or being popped this edge
   assign accept = win_any & ((state_q == IDLE) | out_ready);

   // grant is suppressed while reset is held even if requests are present
   assign gnt = (accept & rst_n) ? win_onehot : '0;

   assign out       = out_q;
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q == HOLD);

   // next-state: capture on accept, drain to IDLE on pop with no request, else hold
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
`ifdef MUX8_ARB_RR_EN
      ptr_d   = ptr_q;
`endif
      if (accept) begin
         state_d = HOLD;
         out_d   = mux_out;
`ifdef MUX8_ARB_RR_EN
         ptr_d   = win_idx + 2'd1;
`endif
      end else if ((state_q == HOLD) && out_ready) begin
         state_d = IDLE;
      end
   end

   // state, output byte and priority pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         out_q   <= '0;
`ifdef MUX8_ARB_RR_EN
         ptr_q   <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
`ifdef MUX8_ARB_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

endmodule
